serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor: D = A - B - Bin, one bit per clock, LSB first.
//  Inverse operation of the 4-bit ripple adder. Shares its A/B/carry port style
//  so the same operand vectors can be replayed against it.
//  Start/Busy/Done handshake so a controller or bench can sequence operations.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  Clk    in   1      rising-edge clock (single clock domain)
//  Rst_n  in   1      asynchronous, active-low reset
//  Start  in   1      request; sampled on Clk rising edge
//  A      in   WIDTH  minuend; captured when Start is accepted
//  B      in   WIDTH  subtrahend; captured when Start is accepted
//  Bin    in   1      borrow-in; captured when Start is accepted
//  Busy   out  1      high while bits are being processed
//  Done   out  1      single-cycle pulse: D/Bout valid
//  D      out  WIDTH  difference; holds until the next accepted Start
//  Bout   out  1      borrow-out, i.e. A < B+Bin unsigned; holds like D
// BEHAVIOUR
//  Reset (Rst_n=0, asynchronous): state=IDLE. Busy=0, Done=0, D=0, Bout=0.
//   Counter, operand shift registers and borrow flop are cleared.
//  States: IDLE, SHIFT, DONE.
//   IDLE : Start=1 -> capture A,B into shift regs, borrow<=Bin, cnt<=0 -> SHIFT.
//   SHIFT: each cycle:
//     di = a0^b0^br; br <= (~a0&b0) | (~(a0^b0)&br).
//     di shifts into D from the MSB end. A and B shift right. cnt<=cnt+1.
//     When cnt==WIDTH-1, latch the final borrow into Bout -> DONE.
//   DONE : Done=1 for exactly this cycle.
//     Start=1 -> accept new operands -> SHIFT. Otherwise -> IDLE.
//  Busy=1 exactly in SHIFT. Done=1 exactly in DONE (registered outputs).
//  Latency: Start accepted at edge k. Busy is high during cycles k+1..k+WIDTH.
//   Done is high in cycle k+WIDTH+1. Back-to-back throughput: 1 op per WIDTH+1 cycles.
//  Start while Busy: ignored, no queueing, operands unchanged.
//  D during SHIFT is partial and is not valid until Done.
//   D/Bout hold their final values in IDLE.
//  Arithmetic: modulo 2^WIDTH. Bout=1 iff A < B+Bin (unsigned).
//   Overflow detection is not required.
//  cnt width = $clog2(WIDTH). No wrap beyond WIDTH-1.
//  Reset asserted mid-operation: immediate abort to reset values. No Done pulse.
//  A/B/Bin changing after capture has no effect on the running operation.
// STRUCTURE
//  Shared package/include (sub_defs.vh):
//   - state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2
//   - default WIDTH
//  Sub-module full_subtractor (X, Y, Bi -> Dif, Bo):
//   - combinational 1-bit cell, instanced once, fed by the a0/b0/br flops
//  Top contains the FSM, counter, shift registers and borrow flop.
// TESTING (WIDTH=4, 10-unit clock; check D/Bout on the Done cycle)
//  1 A=1,B=3,Bin=0 -> D=4'b1110, Bout=1. Done exactly 5 cycles after Start edge.
//  2 A=2,B=6,Bin=0 -> D=4'b1100, Bout=1.
//    A=9,B=8,Bin=0 -> D=4'b0001, Bout=0.
//    A=8,B=9,Bin=1 -> D=4'b1110, Bout=1.
//  3 Back-to-back: Start held high through DONE. Second op A=4,B=12,Bin=1:
//    D=4'b0111, Bout=1. No IDLE cycle between ops. Busy low only in the DONE cycle.
//  4 Start pulsed and A/B toggled while Busy -> result of the first op unchanged.
//    Exactly one Done pulse.
//  5 Rst_n low in the 2nd SHIFT cycle -> Busy, Done, D, Bout all 0 immediately.
//    After release, no Done until a new Start.
//  6 Exhaustive sweep: all A, B, Bin combinations vs the reference model
//    {Bout,D} = {1'b0,A} - B - Bin. D and Bout stable while idle.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/Busy/Done operand bus for the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: dif = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic dif,
  output logic bo
);

  assign dif = x ^ y ^ bi;
  assign bo  = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock, start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  logic dif;
  logic bo;
  logic accept;

  full_subtractor u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .dif(dif),
    .bo (bo)
  );

  // Start is honoured only outside SHIFT; DONE may chain straight into a new op.
  assign accept = bus.start && (state_q != StShift);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    d_d     = d_q;
    bout_d  = bout_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        d_d  = {dif, d_q[WIDTH-1:1]};
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        br_d = bo;
        if (cnt_q == CntLast) begin
          bout_d  = bo;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = (state_q == StShift);
  assign bus.done = (state_q == StDone);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_d;
    logic         exp_bout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one op from IDLE and wait (bounded) for Done; lat=0 means no Done seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bout, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat  = 0;
    d    = 'x;
    bout = 1'bx;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat  = i;
        d    = bus.d;
        bout = bus.bout;
        break;
      end
    end
  endtask

  vec_t         vecs[8];
  logic [W-1:0] d;
  logic         bout;
  int           lat;
  int           dones;
  logic [4:0]   model;

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    vecs[0] = '{a: 4'd1,  b: 4'd3,  bin: 1'b0, exp_d: 4'b1110, exp_bout: 1'b1};
    vecs[1] = '{a: 4'd2,  b: 4'd6,  bin: 1'b0, exp_d: 4'b1100, exp_bout: 1'b1};
    vecs[2] = '{a: 4'd9,  b: 4'd8,  bin: 1'b0, exp_d: 4'b0001, exp_bout: 1'b0};
    vecs[3] = '{a: 4'd8,  b: 4'd9,  bin: 1'b1, exp_d: 4'b1110, exp_bout: 1'b1};
    vecs[4] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, exp_d: 4'b1111, exp_bout: 1'b1};
    vecs[5] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, exp_d: 4'b1111, exp_bout: 1'b0};
    vecs[6] = '{a: 4'd7,  b: 4'd7,  bin: 1'b0, exp_d: 4'b0000, exp_bout: 1'b0};
    vecs[7] = '{a: 4'd5,  b: 4'd3,  bin: 1'b1, exp_d: 4'b0001, exp_bout: 1'b0};

    // Reset values
    #12;
    check("reset_outputs", {28'd0, bus.busy, bus.done, bus.bout, 1'b0} | {28'd0, bus.d}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bout, lat);
      check($sformatf("vec%0d_result", i), {27'd0, bout, d}, {27'd0, vecs[i].exp_bout, vecs[i].exp_d});
      check($sformatf("vec%0d_latency", i), lat, 5);
    end

    // Back-to-back: start held through DONE, second operands applied while busy
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'd9; bus.b = 4'd8; bus.bin = 1'b0;
    @(posedge clk);
    #1;
    bus.a = 4'd4; bus.b = 4'd12; bus.bin = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("b2b_first_busy%0d", i), {30'd0, bus.busy, bus.done},
            (i < 5) ? 32'd2 : 32'd1);
    end
    check("b2b_first_result", {27'd0, bus.bout, bus.d}, {27'd0, 1'b0, 4'b0001});
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) check("b2b_no_idle_gap", {31'd0, bus.busy}, 32'd1);
      if (bus.done) begin
        dones++;
        check("b2b_second_result", {27'd0, bus.bout, bus.d}, {27'd0, 1'b1, 4'b0111});
        check("b2b_second_latency", i, 5);
      end
    end
    check("b2b_second_done_seen", dones, 1);

    // Start pulsed and operands toggled while busy
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'd1; bus.b = 4'd3; bus.bin = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check("busy_start_result", {27'd0, bus.bout, bus.d}, {27'd0, 1'b1, 4'b1110});
      end
      bus.start = (i == 2);
      bus.a     = (i[0]) ? 4'd15 : 4'd6;
      bus.b     = (i[0]) ? 4'd0 : 4'd2;
      bus.bin   = i[0];
    end
    check("busy_start_one_done", dones, 1);

    // Reset during the second SHIFT cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'd2; bus.b = 4'd6; bus.bin = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", {27'd0, bus.busy, bus.done, bus.bout, 2'd0} | {28'd0, bus.d}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("midop_reset_quiet", dones, 0);
    check("midop_reset_hold", {27'd0, bus.bout, bus.d}, 32'd0);

    // Exhaustive sweep against a subtraction model
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          model = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - {4'd0, 1'(ic)};
          run_op(4'(ia), 4'(ib), 1'(ic), d, bout, lat);
          check($sformatf("sweep_a%0d_b%0d_bin%0d", ia, ib, ic), {26'd0, lat == 5, bout, d},
                {26'd0, 1'b1, model});
          @(negedge clk);
          @(negedge clk);
          check($sformatf("sweep_idle_hold_a%0d_b%0d_bin%0d", ia, ib, ic),
                {26'd0, bus.busy, bus.bout, bus.d}, {26'd0, 1'b0, model});
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
